// File: rtl/uart_readout_pkg.sv
// Shared types and constants for the UART readout arbiter.
// Build option: UART_READOUT_ARB_CHECKSUM_EN adds a trailing XOR checksum byte.
package uart_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
`ifdef UART_READOUT_ARB_CHECKSUM_EN
    ,
    ST_CHECK   = 2'd3
`endif
  } state_e;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Bytes per packet: header + payload (+ checksum when compiled in).
  function automatic int pkt_len(input int word_bytes);
`ifdef UART_READOUT_ARB_CHECKSUM_EN
    return word_bytes + 2;
`else
    return word_bytes + 1;
`endif
  endfunction

endpackage

// File: rtl/uart_readout_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the stored pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o,
  output logic [3:0]   gnt_id_o
);

  logic [3:0] ptr_q, ptr_d;
  logic       found;

  // Pick the first request at or above the pointer, else wrap to the lowest one.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = 4'd0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_i[k] && (k >= int'(ptr_q))) begin
          found    = 1'b1;
          gnt_o[k] = 1'b1;
          gnt_id_o = 4'(k);
          ptr_d    = (k == N - 1) ? 4'd0 : 4'(k + 1);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!found && req_i[k]) begin
          found    = 1'b1;
          gnt_o[k] = 1'b1;
          gnt_id_o = 4'(k);
          ptr_d    = (k == N - 1) ? 4'd0 : 4'(k + 1);
        end
      end
    end
  end

  // Pointer register; index 0 has top priority after reset.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 4'd0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_readout_arb.sv
// UART readout arbiter: grants one requester, then streams header + payload
// bytes (MSB first) to a UART TX FIFO with busy back-pressure.
// Build option: UART_READOUT_ARB_CHECKSUM_EN appends an XOR checksum byte.
module uart_readout_arb
  import uart_readout_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0] data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [7:0]                    tx_data_o,
  output logic                          tx_en_o,
  input  logic                          tx_busy_i,
  output logic                          active_o,
  output logic [3:0]                    grant_id_o
);

  localparam int WW      = WORD_BYTES * 8;
  localparam int CW      = 4;
  localparam int PKT_LEN = pkt_len(WORD_BYTES);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   shadow_q, shadow_d;
  logic [3:0]      gid_q, gid_d;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
`endif

  logic [NUM_REQ-1:0] gnt;
  logic [3:0]         gnt_id;
  logic               arb_en;
  logic               accept;
  logic               last_byte;
  logic [7:0]         byte_mux;

  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Reset is folded into the outputs so an abandoned packet stops at once.
  assign active_o   = (state_q != ST_IDLE) && !rst;
  assign tx_en_o    = active_o & ~tx_busy_i;
  assign accept     = tx_en_o;
  assign ack_o      = gnt;
  assign grant_id_o = gid_q;
  assign tx_data_o  = active_o ? byte_mux : 8'h00;
  assign last_byte  = (cnt_q == CW'(PKT_LEN - 1));

  // Next-state, byte selection and datapath updates; advance only on accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    gid_d    = gid_q;
    byte_mux = 8'h00;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) shadow_d = data_i[k*WW +: WW];
          end
          gid_d   = gnt_id;
          cnt_d   = '0;
          state_d = ST_HEADER;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
          xor_d   = 8'h00;
`endif
        end
      end
      ST_HEADER: begin
        byte_mux = {HDR_NIBBLE, gid_q};
        if (accept) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_PAYLOAD;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
          xor_d   = xor_q ^ byte_mux;
`endif
        end
      end
      ST_PAYLOAD: begin
        byte_mux = shadow_q[WW-1 -: 8];
        if (accept) begin
          shadow_d = shadow_q << 8;
          cnt_d    = cnt_q + 1'b1;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
          xor_d    = xor_q ^ byte_mux;
          if (cnt_q == CW'(WORD_BYTES)) state_d = ST_CHECK;
`else
          if (last_byte) state_d = ST_IDLE;
`endif
        end
      end
`ifdef UART_READOUT_ARB_CHECKSUM_EN
      ST_CHECK: begin
        byte_mux = xor_q;
        if (accept && last_byte) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      gid_q    <= 4'd0;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
      xor_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      gid_q    <= gid_d;
`ifdef UART_READOUT_ARB_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_readout_arb.sv
// Directed self-checking bench for uart_readout_arb (default build).
module tb_uart_readout_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_i = 4'b0;
  logic [127:0] data_i;
  logic [3:0]   ack_o;
  logic [7:0]   tx_data_o;
  logic         tx_en_o;
  logic         tx_busy_i = 1'b0;
  logic         active_o;
  logic [3:0]   grant_id_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] byte_log [$];
  logic [3:0] ack_log  [$];
  int         ack_cyc  [$];

  logic [7:0] exp_all [25] = '{
    8'hA0, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
    8'hA1, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
    8'hA2, 8'h11, 8'h22, 8'h33, 8'h44,
    8'hA3, 8'h55, 8'h66, 8'h77, 8'h88,
    8'hA0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] exp_single [5] = '{8'hA2, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_stall  [5] = '{8'hA0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] exp_a1     [5] = '{8'hA1, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
  logic [3:0] exp_order  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  uart_readout_arb #(.NUM_REQ(4), .WORD_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .tx_data_o  (tx_data_o),
    .tx_en_o    (tx_en_o),
    .tx_busy_i  (tx_busy_i),
    .active_o   (active_o),
    .grant_id_o (grant_id_o)
  );

  always #5 clk = ~clk;

  // Log accepted bytes and acks with their cycle numbers.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_en_o && !tx_busy_i) byte_log.push_back(tx_data_o);
    if (ack_o != 4'b0) begin
      ack_log.push_back(ack_o);
      ack_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    byte_log.delete();
    ack_log.delete();
    ack_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  int bad;

  initial begin
    data_i = {32'h55667788, 32'h11223344, 32'hCAFEF00D, 32'hDEADBEEF};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_tx_en", 32'(tx_en_o), 0);
    chk("rst_tx_data", 32'(tx_data_o), 0);
    chk("rst_active", 32'(active_o), 0);
    chk("rst_grant_id", 32'(grant_id_o), 0);
    rst = 1'b0;
    clear_logs();

    // Single request on index 2
    req_i = 4'b0100;
    #1 chk("single_ack_comb", 32'(ack_o), 32'h4);
    @(posedge clk);
    @(negedge clk);
    req_i = 4'b0;
    chk("single_active", 32'(active_o), 1);
    chk("single_grant_id", 32'(grant_id_o), 2);
    chk("single_hdr", 32'(tx_data_o), 32'hA2);
    chk("single_tx_en", 32'(tx_en_o), 1);
    chk("single_ack_low", 32'(ack_o), 0);
    repeat (6) @(negedge clk);
    chk("single_nbytes", byte_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("single_byte%0d", i), 32'(byte_log[i]), 32'(exp_single[i]));
    chk("single_nacks", ack_log.size(), 1);
    chk("single_active_end", 32'(active_o), 0);

    // All requests held: order 0,1,2,3,0 with 6-cycle spacing (5 bytes + idle)
    do_reset();
    req_i = 4'b1111;
    repeat (25) @(posedge clk);
    @(negedge clk);
    req_i = 4'b0;
    repeat (8) @(negedge clk);
    chk("rr_nacks", ack_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++) chk($sformatf("rr_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 6);
    chk("rr_nbytes", byte_log.size(), 25);
    for (int i = 0; i < 25; i++) chk($sformatf("rr_byte%0d", i), 32'(byte_log[i]), 32'(exp_all[i]));

    // Busy stall on 2nd payload byte
    do_reset();
    req_i = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_i = 4'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("stall_pre_byte", 32'(tx_data_o), 32'hAD);
    tx_busy_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (tx_en_o !== 1'b0 || tx_data_o !== 8'hAD || active_o !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("stall_hold", bad, 0);
    chk("stall_nbytes_mid", byte_log.size(), 2);
    tx_busy_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("stall_nbytes", byte_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("stall_byte%0d", i), 32'(byte_log[i]), 32'(exp_stall[i]));

    // Reset mid-packet after header accepted
    do_reset();
    req_i = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    req_i = 4'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_tx_en_during", 32'(tx_en_o), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ack", 32'(ack_o), 0);
    chk("midrst_tx_en", 32'(tx_en_o), 0);
    chk("midrst_tx_data", 32'(tx_data_o), 0);
    chk("midrst_active", 32'(active_o), 0);
    chk("midrst_grant_id", 32'(grant_id_o), 0);
    repeat (3) @(negedge clk);
    chk("midrst_nbytes", byte_log.size(), 1);
    chk("midrst_hdr", 32'(byte_log[0]), 32'hA3);
    chk("midrst_nacks", ack_log.size(), 1);
    clear_logs();
    req_i = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_i = 4'b0;
    repeat (6) @(negedge clk);
    chk("postrst_nbytes", byte_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("postrst_byte%0d", i), 32'(byte_log[i]), 32'(exp_a1[i]));

    // Request on index 3 arriving while index 1 is being sent
    do_reset();
    req_i = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_i = 4'b1000;
    chk("late_ack_blocked", 32'(ack_o), 0);
    for (int i = 0; i < 20; i++) begin
      if (ack_log.size() >= 2) break;
      @(negedge clk);
    end
    req_i = 4'b0;
    chk("late_nacks", ack_log.size(), 2);
    chk("late_second_ack", 32'(ack_log[1]), 32'h8);
    chk("late_spacing", ack_cyc[1] - ack_cyc[0], 6);
    repeat (8) @(negedge clk);
    chk("late_nbytes", byte_log.size(), 10);
    chk("late_hdr2", 32'(byte_log[5]), 32'hA3);
    chk("late_byte9", 32'(byte_log[9]), 32'h88);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
